// File: rtl/sevga_vid_capture.sv
// rtl/sevga_vid_capture.sv - SE-VGA video capture: sync lock, position recovery, pixel-pair decode to VRAM byte writes
module sevga_vid_capture #(
    parameter int H_TOTAL      = 1344,
    parameter int V_TOTAL      = 806,
    parameter int H_SYNC_START = 1048,
    parameter int H_SYNC_END   = 1184,
    parameter int V_SYNC_START = 729,
    parameter int PIX_FIRST    = 3,
    parameter int V_ACTIVE     = 684
) (
    input  logic        pixClk,
    input  logic        reset,
    input  logic        nhSync,
    input  logic        nvSync,
    input  logic        vidOut,
    input  logic        capStart,
    input  logic        bufSel,
    output logic [14:0] capAddr,
    output logic [7:0]  capData,
    output logic        capLane,
    output logic        capWrite,
    output logic        locked,
    output logic        capBusy,
    output logic        capDone,
    output logic        capErr,
    output logic [15:0] pairErrCnt
);

    typedef enum logic [2:0] {
        ST_UNLOCKED,
        ST_HSEEN,
        ST_HLOCK,
        ST_LOCKED,
        ST_CAPTURE
    } state_t;

    state_t      state_q, state_d;
    logic        nh_prev_q, nh_prev_d;
    logic        nv_prev_q, nv_prev_d;
    logic [10:0] hpos_q, hpos_d;
    logic [9:0]  vpos_q, vpos_d;
    logic [6:0]  shift_q, shift_d;
    logic        first_q, first_d;
    logic        buf_q, buf_d;
    logic [14:0] cap_addr_q, cap_addr_d;
    logic [7:0]  cap_data_q, cap_data_d;
    logic        cap_lane_q, cap_lane_d;
    logic        cap_write_q, cap_write_d;
    logic        locked_q, locked_d;
    logic        cap_busy_q, cap_busy_d;
    logic        cap_done_q, cap_done_d;
    logic        cap_err_q, cap_err_d;
    logic [15:0] pair_cnt_q, pair_cnt_d;

    logic        hfall, hrise, vfall, sync_err, frame_start, frame_end;
    logic [10:0] pix_off;
    logic        in_pix, cap_pix, blank, new_bit;

    always_comb begin
        hfall       = nh_prev_q & ~nhSync;
        hrise       = ~nh_prev_q & nhSync;
        vfall       = nv_prev_q & ~nvSync;
        sync_err    = (hfall && hpos_q != 11'(H_SYNC_START))
                   || (hrise && hpos_q != 11'(H_SYNC_END))
                   || (vfall && vpos_q != 10'(V_SYNC_START - 1));
        frame_start = hfall && !vfall && vpos_q == 10'(V_TOTAL - 1);
        frame_end   = hfall && !vfall && vpos_q == 10'(V_ACTIVE - 1);

        nh_prev_d   = nhSync;
        nv_prev_d   = nvSync;
        state_d     = state_q;
        shift_d     = shift_q;
        first_d     = first_q;
        buf_d       = buf_q;
        cap_addr_d  = cap_addr_q;
        cap_data_d  = cap_data_q;
        cap_lane_d  = cap_lane_q;
        cap_write_d = 1'b0;
        cap_busy_d  = cap_busy_q;
        cap_done_d  = 1'b0;
        cap_err_d   = cap_err_q;
        pair_cnt_d  = pair_cnt_q;

        if (hfall) begin
            hpos_d = 11'(H_SYNC_START + 1);
        end else if (hpos_q == 11'(H_TOTAL - 1)) begin
            hpos_d = '0;
        end else begin
            hpos_d = hpos_q + 11'd1;
        end

        vpos_d = vpos_q;
        if (hfall) begin
            if (vfall) begin
                vpos_d = 10'(V_SYNC_START);
            end else if (vpos_q == 10'(V_TOTAL - 1)) begin
                vpos_d = '0;
            end else begin
                vpos_d = vpos_q + 10'd1;
            end
        end

        // Each pixel spans two samples; even offsets carry the data, odd ones are the pair check.
        pix_off = hpos_q - 11'(PIX_FIRST);
        in_pix  = (hpos_q >= 11'(PIX_FIRST)) && (pix_off < 11'd1024);
        cap_pix = (state_q == ST_CAPTURE) && !vpos_q[0] && in_pix && !sync_err;
        blank   = (pix_off[9:1] == 9'h1FF);
        new_bit = blank ? 1'b0 : ~vidOut;

        if (cap_pix) begin
            if (!pix_off[0]) begin
                shift_d = {shift_q[5:0], new_bit};
                first_d = vidOut;
                if (pix_off[3:0] == 4'd14) begin
                    cap_write_d = 1'b1;
                    cap_data_d  = {shift_q, new_bit};
                    cap_addr_d  = {buf_q, vpos_q[9:1], pix_off[9:5]};
                    cap_lane_d  = pix_off[4];
                end
            end else if (!blank && vidOut != first_q && pair_cnt_q != 16'hFFFF) begin
                pair_cnt_d = pair_cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_UNLOCKED: if (hfall) state_d = ST_HSEEN;
            ST_HSEEN:    if (hfall && hpos_q == 11'(H_SYNC_START)) state_d = ST_HLOCK;
            ST_HLOCK:    if (vfall) state_d = ST_LOCKED;
            ST_LOCKED: begin
                if (sync_err) begin
                    state_d    = ST_UNLOCKED;
                    cap_err_d  = 1'b1;
                    cap_busy_d = 1'b0;
                end else if (capStart) begin
                    // A start coinciding with the frame boundary waits for the following frame.
                    cap_busy_d = 1'b1;
                    buf_d      = bufSel;
                    cap_err_d  = 1'b0;
                    pair_cnt_d = '0;
                end else if (cap_busy_q && frame_start) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (sync_err) begin
                    state_d    = ST_UNLOCKED;
                    cap_err_d  = 1'b1;
                    cap_busy_d = 1'b0;
                end else if (frame_end) begin
                    state_d    = ST_LOCKED;
                    cap_done_d = 1'b1;
                    cap_busy_d = 1'b0;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase

        locked_d = (state_d == ST_LOCKED) || (state_d == ST_CAPTURE);
    end

    always_ff @(posedge pixClk) begin
        if (reset) begin
            state_q     <= ST_UNLOCKED;
            nh_prev_q   <= 1'b1;
            nv_prev_q   <= 1'b1;
            hpos_q      <= '0;
            vpos_q      <= '0;
            shift_q     <= '0;
            first_q     <= 1'b0;
            buf_q       <= 1'b0;
            cap_addr_q  <= '0;
            cap_data_q  <= '0;
            cap_lane_q  <= 1'b0;
            cap_write_q <= 1'b0;
            locked_q    <= 1'b0;
            cap_busy_q  <= 1'b0;
            cap_done_q  <= 1'b0;
            cap_err_q   <= 1'b0;
            pair_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            nh_prev_q   <= nh_prev_d;
            nv_prev_q   <= nv_prev_d;
            hpos_q      <= hpos_d;
            vpos_q      <= vpos_d;
            shift_q     <= shift_d;
            first_q     <= first_d;
            buf_q       <= buf_d;
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
            cap_lane_q  <= cap_lane_d;
            cap_write_q <= cap_write_d;
            locked_q    <= locked_d;
            cap_busy_q  <= cap_busy_d;
            cap_done_q  <= cap_done_d;
            cap_err_q   <= cap_err_d;
            pair_cnt_q  <= pair_cnt_d;
        end
    end

    assign capAddr    = cap_addr_q;
    assign capData    = cap_data_q;
    assign capLane    = cap_lane_q;
    assign capWrite   = cap_write_q;
    assign locked     = locked_q;
    assign capBusy    = cap_busy_q;
    assign capDone    = cap_done_q;
    assign capErr     = cap_err_q;
    assign pairErrCnt = pair_cnt_q;

endmodule

// File: tb/tb_sevga_vid_capture.sv
// tb/tb_sevga_vid_capture.sv - directed bench for sevga_vid_capture on a shortened frame
module tb_sevga_vid_capture;

    localparam int HT    = 1050;
    localparam int VT    = 8;
    localparam int HSS   = 1030;
    localparam int HSE   = 1040;
    localparam int VSS   = 6;
    localparam int PF    = 3;
    localparam int VA    = 4;
    localparam int FRAME = HT * VT;
    localparam int LIM   = 3 * FRAME;

    logic        pixClk, reset, nhSync, nvSync, vidOut, capStart, bufSel;
    logic [14:0] capAddr;
    logic [7:0]  capData;
    logic        capLane, capWrite, locked, capBusy, capDone, capErr;
    logic [15:0] pairErrCnt;

    sevga_vid_capture #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_SYNC_START(VSS), .PIX_FIRST(PF), .V_ACTIVE(VA)
    ) dut (
        .pixClk(pixClk), .reset(reset), .nhSync(nhSync), .nvSync(nvSync),
        .vidOut(vidOut), .capStart(capStart), .bufSel(bufSel),
        .capAddr(capAddr), .capData(capData), .capLane(capLane),
        .capWrite(capWrite), .locked(locked), .capBusy(capBusy),
        .capDone(capDone), .capErr(capErr), .pairErrCnt(pairErrCnt)
    );

    int checks = 0;
    int failures = 0;

    int src_h, src_v, g_vn, g_hs0, g_off, g_k;
    logic [7:0] pat;
    logic       cur_buf, corr_arm, err_arm;
    int         corr_v, corr_h;

    int          wr_cnt, bad_cnt, done_cnt;
    logic [14:0] first_addr, last_addr;
    logic [7:0]  first_data, last_data;
    logic        first_lane, last_lane;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixClk);
        #2;
    endtask

    initial begin
        pixClk = 1'b0;
        forever #5 pixClk = ~pixClk;
    end

    // Reference video source, launched on the falling edge
    initial begin
        nhSync = 1'b1; nvSync = 1'b1; vidOut = 1'b0;
        src_h = HT - 1; src_v = 0;
        forever begin
            @(negedge pixClk);
            if (err_arm && src_h == HSE) err_arm = 1'b0;
            if (src_h == HSS) src_v = (src_v == VT - 1) ? 0 : src_v + 1;
            src_h = (src_h == HT - 1) ? 0 : src_h + 1;
            g_vn  = (src_h == HSS) ? ((src_v == VT - 1) ? 0 : src_v + 1) : src_v;
            g_hs0 = err_arm ? HSS + 2 : HSS;
            nhSync = !(src_h >= g_hs0 && src_h < HSE);
            nvSync = !(g_vn >= VSS && g_vn <= VSS + 1);
            if (src_v < VA && src_h >= PF && src_h < PF + 1024) begin
                g_off = src_h - PF;
                if (g_off == 1022) vidOut = 1'b0;
                else if (g_off == 1023) vidOut = 1'b1;
                else begin
                    g_k = 7 - ((g_off >> 1) & 7);
                    vidOut = ~pat[g_k];
                    if (corr_arm && src_v == corr_v && src_h == corr_h) vidOut = ~vidOut;
                end
            end else begin
                vidOut = 1'b0;
            end
        end
    end

    task automatic mon_write();
        int off;
        logic [5:0]  nn;
        logic [9:0]  vt;
        logic [14:0] ea;
        logic [7:0]  ed;
        off = src_h - (PF + 14);
        if (off < 0 || off % 16 != 0 || off / 16 > 63) begin
            bad_cnt++;
        end else begin
            nn = 6'(off / 16);
            vt = 10'(src_v);
            ea = {cur_buf, vt[9:1], nn[5:1]};
            ed = (nn == 6'd63) ? (pat & 8'hFE) : pat;
            if (capAddr !== ea || capData !== ed || capLane !== nn[0]) bad_cnt++;
        end
        if (wr_cnt == 0) begin
            first_addr = capAddr; first_data = capData; first_lane = capLane;
        end
        last_addr = capAddr; last_data = capData; last_lane = capLane;
        wr_cnt++;
    endtask

    initial begin
        wr_cnt = 0; bad_cnt = 0; done_cnt = 0;
        forever begin
            @(posedge pixClk);
            #1;
            if (capDone === 1'b1) done_cnt++;
            if (capWrite === 1'b1) mon_write();
        end
    end

    task automatic clr_mon();
        wr_cnt = 0; bad_cnt = 0; done_cnt = 0;
    endtask

    task automatic wait_locked(input string tag);
        int n;
        n = 0;
        while (locked !== 1'b1 && n < LIM) begin tick(); n++; end
        chk(tag, 32'(locked), 1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < LIM) begin tick(); n++; end
        chk(tag, 32'(n < LIM), 1);
    endtask

    task automatic wait_src(input int v, input int h, input string tag);
        int n;
        n = 0;
        while (!(src_v == v && src_h == h) && n < LIM) begin tick(); n++; end
        chk(tag, 32'(n < LIM), 1);
    endtask

    task automatic start_cap(input logic b, input logic [7:0] p);
        bufSel = b; cur_buf = b; pat = p;
        clr_mon();
        capStart = 1'b1;
        tick();
        capStart = 1'b0;
        chk("busy_after_start", 32'(capBusy), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 32'(capAddr), 0);
        chk({tag, "_data"}, 32'(capData), 0);
        chk({tag, "_lane"}, 32'(capLane), 0);
        chk({tag, "_write"}, 32'(capWrite), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_busy"}, 32'(capBusy), 0);
        chk({tag, "_done"}, 32'(capDone), 0);
        chk({tag, "_err"}, 32'(capErr), 0);
        chk({tag, "_pair"}, 32'(pairErrCnt), 0);
    endtask

    initial begin
        reset = 1'b1; capStart = 1'b0; bufSel = 1'b0; cur_buf = 1'b0;
        pat = 8'hA5; corr_arm = 1'b0; err_arm = 1'b0; corr_v = 0; corr_h = 0;
        repeat (3) tick();
        chk_zero("rst");
        reset = 1'b0;

        wait_locked("lock_reached");
        chk("lock_line", src_v, VSS - 1);
        chk("lock_hpos", src_h, HSS);
        chk("unarmed_writes", wr_cnt, 0);
        chk("unarmed_busy", 32'(capBusy), 0);

        start_cap(1'b1, 8'hA5);
        wait_done("cap1_done_seen");
        repeat (20) tick();
        chk("cap1_writes", wr_cnt, 128);
        chk("cap1_fields", bad_cnt, 0);
        chk("cap1_first_addr", 32'(first_addr), 32'h4000);
        chk("cap1_first_lane", 32'(first_lane), 0);
        chk("cap1_first_data", 32'(first_data), 32'hA5);
        chk("cap1_last_addr", 32'(last_addr), 32'h403F);
        chk("cap1_last_lane", 32'(last_lane), 1);
        chk("cap1_last_data", 32'(last_data), 32'hA4);
        chk("cap1_done_cnt", done_cnt, 1);
        chk("cap1_pair", 32'(pairErrCnt), 0);
        chk("cap1_busy", 32'(capBusy), 0);
        chk("cap1_err", 32'(capErr), 0);
        chk("cap1_locked", 32'(locked), 1);

        corr_v = 2; corr_h = 90; corr_arm = 1'b1;
        start_cap(1'b0, 8'h3D);
        wait_done("cap2_done_seen");
        repeat (20) tick();
        corr_arm = 1'b0;
        chk("cap2_pair", 32'(pairErrCnt), 1);
        chk("cap2_writes", wr_cnt, 128);
        chk("cap2_fields", bad_cnt, 0);
        chk("cap2_first_addr", 32'(first_addr), 32'h0000);
        chk("cap2_last_addr", 32'(last_addr), 32'h003F);
        chk("cap2_last_data", 32'(last_data), 32'h3C);

        start_cap(1'b1, 8'hA5);
        wait_src(1, 100, "err_line_reached");
        chk("err_pre_writes", wr_cnt, 64);
        chk("err_pre_busy", 32'(capBusy), 1);
        err_arm = 1'b1;
        begin : wait_err
            int n;
            n = 0;
            while (capErr !== 1'b1 && n < 2000) begin tick(); n++; end
        end
        chk("err_flag", 32'(capErr), 1);
        chk("err_locked", 32'(locked), 0);
        chk("err_busy", 32'(capBusy), 0);
        repeat (3000) tick();
        chk("err_post_writes", wr_cnt, 64);
        chk("err_no_done", done_cnt, 0);
        chk("err_sticky", 32'(capErr), 1);

        wait_locked("relock1");
        start_cap(1'b0, 8'h5A);
        chk("restart_err_clr", 32'(capErr), 0);
        wait_src(0, 500, "rst_point_reached");
        chk("rst_pre_writes", wr_cnt, 31);
        chk("rst_pre_busy", 32'(capBusy), 1);
        reset = 1'b1;
        tick();
        chk_zero("rst2");
        reset = 1'b0;
        wait_src(4, 0, "relock_window");
        chk("relock_not_early", 32'(locked), 0);
        wait_locked("relock2");
        chk("relock2_line", src_v, VSS - 1);
        chk("relock2_err", 32'(capErr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
